// File: rtl/parity_tx.sv
// parity_tx: serial byte transmitter for the 8-bit parity link.
// It accepts one byte over a valid/ready handshake and computes even or odd parity.
// The frame goes out on txd as: start(0), 8 data bits LSB first, parity, stop(1).
// Every bit is held for CLKS_PER_BIT clock cycles.
module parity_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       par_odd,
    output logic       txd,
    output logic       busy,
    output logic       par_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_data;
    logic             r_par;
    logic             r_txd;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       w_bit_next;
    logic             w_accept;
    logic             w_cnt_last;
    logic             w_txd_next;

    assign w_cnt_last = (r_cnt == CNT_LAST);

    // Next-state, bit-timing and bit-index logic for the frame sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit_idx;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (din_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_START;
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                end
            end
            S_START: begin
                if (w_cnt_last) begin
                    w_state_next = S_DATA;
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    w_cnt_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_PARITY;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (w_cnt_last) begin
                    w_state_next = S_STOP;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_cnt_last) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_bit_next   = '0;
            end
        endcase
    end

    // Line level for the state being entered. Registering it keeps txd glitch-free.
    // The data and parity registers are already loaded by the time DATA or PARITY is entered.
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            S_IDLE:   w_txd_next = 1'b1;
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = r_data[w_bit_next];
            S_PARITY: w_txd_next = r_par;
            S_STOP:   w_txd_next = 1'b1;
            default:  w_txd_next = 1'b1;
        endcase
    end

    // State, counters, captured byte/parity and the registered line driver.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
            r_par     <= 1'b0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_next;
            r_txd     <= w_txd_next;
            if (w_accept) begin
                r_data <= din;
                r_par  <= (^din) ^ par_odd;
            end
        end
    end

    assign txd       = r_txd;
    assign busy      = (r_state != S_IDLE);
    assign din_ready = (r_state == S_IDLE);
    assign par_out   = r_par;

endmodule

// File: tb/tb_parity_tx.sv
// tb_parity_tx: directed, table-driven bench for parity_tx with CLKS_PER_BIT=4.
module tb_parity_tx;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 11 * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       par_odd;
    logic       txd;
    logic       busy;
    logic       par_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_start_cyc;

    parity_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .par_odd   (par_odd),
        .txd       (txd),
        .busy      (busy),
        .par_out   (par_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count used to measure start-bit spacing.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] din;
        logic       par_odd;
        logic       exp_par;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected line level for sample k of a frame, with k counted from the first start-bit cycle.
    function automatic logic exp_bit(input logic [7:0] d, input logic p, input int k);
        int b;
        b = k / CPB;
        if (b == 0)       return 1'b0;
        else if (b <= 8)  return d[b-1];
        else if (b == 9)  return p;
        else              return 1'b1;
    endfunction

    // Call at a negedge with din/din_valid/par_odd already driven.
    // The task checks every cycle of the resulting frame.
    // With hold_valid, din_valid stays high and din switches to next_din once the byte is accepted.
    // mutate_k >= 0 drives din=0xFF and par_odd=1 at that frame cycle.
    task automatic run_frame(input logic [7:0] d, input logic p, input string tag,
                             input bit hold_valid, input logic [7:0] next_din, input int mutate_k);
        check({tag, " ready_before_accept"}, din_ready, 1);
        for (int k = 0; k < FRAME_CYC; k++) begin
            @(negedge clk);
            if (k == 0) begin
                last_start_cyc = cyc;
                if (hold_valid) din = next_din;
                else            din_valid = 1'b0;
            end
            if (k == mutate_k) begin
                din     = 8'hFF;
                par_odd = 1'b1;
            end
            check($sformatf("%s txd k=%0d", tag, k), txd, exp_bit(d, p, k));
            check($sformatf("%s busy k=%0d", tag, k), busy, 1);
            check($sformatf("%s ready_low k=%0d", tag, k), din_ready, 0);
        end
        check({tag, " par_out"}, par_out, p);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " idle txd"}, txd, 1);
        check({tag, " idle busy"}, busy, 0);
        check({tag, " idle ready"}, din_ready, 1);
    endtask

    initial begin
        int first_start;

        // Hand-computed parities, e.g. 0x07 has three ones, so even parity gives 1 and odd gives 0.
        vecs[0] = '{din: 8'hA5, par_odd: 1'b0, exp_par: 1'b0};
        vecs[1] = '{din: 8'h07, par_odd: 1'b1, exp_par: 1'b0};
        vecs[2] = '{din: 8'h07, par_odd: 1'b0, exp_par: 1'b1};
        vecs[3] = '{din: 8'h00, par_odd: 1'b1, exp_par: 1'b1};
        vecs[4] = '{din: 8'hFF, par_odd: 1'b0, exp_par: 1'b0};

        rst       = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;
        par_odd   = 1'b0;

        // Reset held for three cycles; outputs must sit at idle values throughout.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset txd %0d", i), txd, 1);
            check($sformatf("reset busy %0d", i), busy, 0);
            check($sformatf("reset par_out %0d", i), par_out, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_reset ready", din_ready, 1);
        check("post_reset txd", txd, 1);
        check("post_reset busy", busy, 0);
        check("post_reset par_out", par_out, 0);

        // Single frames with single-cycle valid, including the parity sweep.
        for (int v = 0; v < 5; v++) begin
            din       = vecs[v].din;
            par_odd   = vecs[v].par_odd;
            din_valid = 1'b1;
            run_frame(vecs[v].din, vecs[v].exp_par, $sformatf("vec%0d", v), 1'b0, 8'h00, -1);
            @(negedge clk);
            check_idle($sformatf("vec%0d", v));
        end

        // Back-to-back frames with valid held high: 0x3C then 0xC3, both with even parity 0.
        din       = 8'h3C;
        par_odd   = 1'b0;
        din_valid = 1'b1;
        run_frame(8'h3C, 1'b0, "b2b_first", 1'b1, 8'hC3, -1);
        first_start = last_start_cyc;
        @(negedge clk);
        check_idle("b2b_gap");
        run_frame(8'hC3, 1'b0, "b2b_second", 1'b0, 8'h00, -1);
        check("b2b start spacing", last_start_cyc - first_start, FRAME_CYC + 1);
        @(negedge clk);
        check_idle("b2b_end");

        // Inputs change during DATA; the frame must still carry 0x12 with even parity 0.
        din       = 8'h12;
        par_odd   = 1'b0;
        din_valid = 1'b1;
        run_frame(8'h12, 1'b0, "mutate", 1'b0, 8'h00, 10);
        @(negedge clk);
        check_idle("mutate");
        par_odd = 1'b0;

        // Reset during DATA bit 3, then a clean 0x81 frame with even parity 0.
        din       = 8'h5A;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int k = 1; k <= 17; k++) @(negedge clk);
        check("pre_abort busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort txd", txd, 1);
        check("abort busy", busy, 0);
        check("abort ready", din_ready, 1);
        check("abort par_out", par_out, 0);
        @(negedge clk);
        check("abort still idle txd", txd, 1);
        din       = 8'h81;
        par_odd   = 1'b0;
        din_valid = 1'b1;
        run_frame(8'h81, 1'b0, "after_abort", 1'b0, 8'h00, -1);
        @(negedge clk);
        check_idle("after_abort");

        // Reset and valid together: reset wins and no frame starts.
        din       = 8'hF0;
        din_valid = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        din_valid = 1'b0;
        check("rst_vs_valid busy", busy, 0);
        check("rst_vs_valid txd", txd, 1);
        @(negedge clk);
        check("rst_vs_valid still idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parity_tx.md
Name: parity_tx

Overview:
- Serial byte transmitter that generates the parity bit on the send side of the team's 8-bit parity link.
- Accepts a byte over a valid/ready handshake and computes even or odd parity.
- Serializes the frame as start bit, 8 data bits LSB first, parity bit, stop bit, with each bit held for a fixed number of clock cycles.
- Feeds the link whose receive side runs the 8-bit parity check.

Parameters:
- CLKS_PER_BIT, default 4: clock cycles per serial bit. Legal range is 2 or more.
- CNT_W, default $clog2(CLKS_PER_BIT): width of the bit-timing counter. Derived; do not override.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- din, input, 8: byte to transmit. Sampled only on an accept cycle.
- din_valid, input, 1: din is valid.
- din_ready, output, 1: block can accept a byte this cycle.
- par_odd, input, 1: parity mode, sampled on an accept cycle. 1 = odd parity, 0 = even parity.
- txd, output, 1: serial line. Idles high.
- busy, output, 1: a frame is in progress.
- par_out, output, 1: parity bit of the most recently accepted byte. Registered.

Behaviour:
- Reset is synchronous and active-high. On a rising clk edge with rst=1:
  - state goes to IDLE; bit counter and timing counter clear.
  - txd=1, busy=0, par_out=0.
  - din_ready=1 from the first cycle after rst deasserts (din_ready = state==IDLE).
  - A reset mid-frame aborts the frame: txd=1 from the next cycle, and no partial bits resume.
- Accept: a byte is accepted on a cycle where din_valid=1 and din_ready=1. On that edge:
  - data register <= din.
  - par_out <= (^din) XOR par_odd. With even parity the total number of ones, including the parity bit, is even; with odd parity it is odd.
  - state <= START.
- After the accept, changes on din, din_valid and par_odd have no effect until the next accept.
- State sequence: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - Each non-IDLE state holds for exactly CLKS_PER_BIT cycles, timed by a counter counting 0..CLKS_PER_BIT-1.
  - DATA repeats 8 times, bit index 0..7, for 8*CLKS_PER_BIT cycles in total.
- txd per state:
  - IDLE: 1.
  - START: 0.
  - DATA: data[bit index].
  - PARITY: par_out.
  - STOP: 1.
  - txd is registered, or decoded from registered state only; it must be glitch-free.
- Latency and frame length:
  - First start-bit cycle on txd is the cycle immediately after the accept edge.
  - Frame length is exactly 11*CLKS_PER_BIT cycles.
  - busy=1 for exactly those 11*CLKS_PER_BIT cycles. busy=0 and din_ready=1 in IDLE.
- Back-to-back: after STOP the block spends one IDLE cycle with txd=1 and din_ready=1.
  - If din_valid is held high, the next start bit begins the following cycle.
  - The minimum frame period is 11*CLKS_PER_BIT+1 cycles.
- din_valid asserted while busy: ignored and not queued. The byte is accepted in the next IDLE cycle only if din_valid is still high.
- rst and din_valid both high on the same edge: reset wins and no byte is accepted.
- No overflow or underflow is possible: single-byte buffering, and the handshake stalls the producer.

Test Plan:
- Reset, CLKS_PER_BIT=4: hold rst 3 cycles, then release.
  - Required: txd=1, busy=0, par_out=0 during and after reset.
  - Required: din_ready=1 on the first cycle after release.
- din=0xA5, par_odd=0, single-cycle valid:
  - Required txd, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 0, 1.
  - Required: par_out=0, busy high for 44 cycles, din_ready low for those 44 cycles.
- Parity sweep:
  - 0x07, par_odd=1 -> parity bit 0.
  - 0x07, par_odd=0 -> parity bit 1.
  - 0x00, par_odd=1 -> parity bit 1.
  - 0xFF, par_odd=0 -> parity bit 0.
  - Required: par_out matches the serialized parity bit in every case.
- Back-to-back with din_valid held high, 0x3C then 0xC3, even parity:
  - Required: the second start bit begins 45 cycles after the first.
  - Required: exactly one idle-high cycle between the frames.
  - Required: parity bits 0 and 0.
- Input changes mid-frame: change din to 0xFF and par_odd to 1 during DATA.
  - Required: serialized bits and parity are unchanged from the originally accepted 0x12, even parity (parity bit 0).
- Reset mid-frame: assert rst for 1 cycle during DATA bit 3.
  - Required: txd=1 and busy=0 on the next cycle.
  - Required: din_ready=1 afterwards, and a new frame for 0x81 transmits correctly.
